imem_responder: RTL and testbench

- Instruction-side memory responder: the far end of the core's fetch interface.
- Accepts a fetch address from the core over a valid/ready request channel and returns a 32-bit instruction word over a valid/ready response channel after a programmable latency.
- Storage is a word array preloaded through a simple program/write port by the testbench or boot loader.
- Replaces the zero-latency combinational instruction source so that multi-cycle fetch can be exercised.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_if.sv | 27 ++
 rtl/imem_array.sv | 32 +++
 rtl/imem_responder.sv | 123 ++++++++++++
 tb/tb_imem_responder.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the instruction-memory
//                responder (handshake states, reset PC, fault data).
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Handshake states of the responder
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte address of word 0; must match the core reset PC
  localparam logic [31:0] RESET_PC    = 32'h8000_0000;
  // ebreak, handy as a program terminator in benches
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  // Word returned alongside resp_err
  localparam logic [31:0] FAULT_DATA  = 32'h0000_0000;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_if
//  Description : Fetch request/response channel between the core (master)
//                and the instruction-memory responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface : imem_if
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
//  Module      : imem_array
//  Description : DEPTH x 32 word store, synchronous write, combinational read.
//                Contents are never cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_array #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Program-port write; the read below sees the pre-edge contents
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : imem_array
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imem_responder
//  Description : Far end of the core fetch interface. Accepts one fetch
//                address at a time, returns the instruction word (or an
//                access fault) after LATENCY cycles, and holds it until the
//                core takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = RESET_PC,
  parameter int unsigned LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  imem_if.slave                    bus,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data
);

  localparam int unsigned AW       = $clog2(DEPTH);
  // Byte span of the array, one bit wider so DEPTH*4 == 2^32 cannot overflow
  localparam logic [32:0] SPAN     = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q,   cnt_d;
  logic [31:0]   data_q,  data_d;
  logic          err_q,   err_d;

  logic [31:0]   w_off;
  logic          w_fault;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;
  logic          w_req_ready;
  logic          w_accept;

  // Address decode: below-base addresses wrap to huge offsets and fault
  assign w_off    = bus.req_addr - BASE_ADDR;
  assign w_fault  = (bus.req_addr[1:0] != 2'b00) || ({1'b0, w_off} >= SPAN);
  assign w_idx    = w_off[AW+1:2];
  assign w_accept = bus.req_valid && w_req_ready;

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (prog_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (w_idx),
    .rdata_o (w_rdata)
  );

  // State, latency counter and response holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= FAULT_DATA;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next state: an accept loads the holding register from IDLE or from a
  // completing RESP, so back-to-back fetches need no extra cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready && !w_accept) begin
          state_d = IDLE;
          data_d  = FAULT_DATA;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase
    if (w_accept) begin
      data_d = w_fault ? FAULT_DATA : w_rdata;
      err_d  = w_fault;
      if (LATENCY == 1) begin
        state_d = RESP;
        cnt_d   = 4'd0;
      end else begin
        state_d = WAIT;
        cnt_d   = CNT_INIT;
      end
    end
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    w_req_ready    = (state_q == IDLE) || ((state_q == RESP) && bus.resp_ready);
    bus.req_ready  = w_req_ready;
    bus.resp_valid = (state_q == RESP);
    bus.resp_data  = data_q;
    bus.resp_err   = err_q;
  end

endmodule : imem_responder
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_responder
//  Description : Self-checking bench. Three responders (latency 1, 4, 8)
//                share clock, reset and program port; one is active at a time.
//                Accepted requests push a modelled response into a queue; a
//                monitor pops and compares whenever a response is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam int NDUT  = 3;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;

  logic          rv  [NDUT];
  logic [31:0]   ra  [NDUT];
  logic          rr  [NDUT];
  logic          rdy [NDUT];
  logic          vld [NDUT];
  logic          err [NDUT];
  logic [31:0]   dat [NDUT];

  logic [31:0]   mem_m [DEPTH];
  exp_t          exp_q [$];
  int            sel;
  int            ecnt;
  int            rmode;
  bit            mon_en;
  bit            hold;
  logic          rdy_s;
  int            errors;
  int            checks;

  always #5 clk = ~clk;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
  endfunction

  imem_if bus [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign bus[g].req_valid  = rv[g];
    assign bus[g].req_addr   = ra[g];
    assign bus[g].resp_ready = rr[g];
    assign rdy[g] = bus[g].req_ready;
    assign vld[g] = bus[g].resp_valid;
    assign err[g] = bus[g].resp_err;
    assign dat[g] = bus[g].resp_data;

    imem_responder #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (RESET_PC),
      .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 4 : 8))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus[g]),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: fault on misalignment or offset beyond the array, else the word
  function automatic exp_t model(input logic [31:0] a);
    exp_t        e;
    logic [31:0] off;
    off = a - RESET_PC;
    if ((a % 4) != 0 || off >= DEPTH * 4) begin
      e.err  = 1'b1;
      e.data = 32'h0;
    end else begin
      e.err  = 1'b0;
      e.data = mem_m[off / 4];
    end
    e.due = 0;
    return e;
  endfunction

  // Scoreboard feed: evaluate each edge; read-before-write on the model
  always @(posedge clk) begin
    exp_t e;
    ecnt++;
    if (rst) begin
      exp_q.delete();
    end else if (rv[sel] && rdy_s) begin
      e     = model(ra[sel]);
      e.due = ecnt + lat_of(sel) - 1;
      exp_q.push_back(e);
    end
    if (prog_we) mem_m[prog_addr] = prog_data;
  end

  // Consumer readiness: always, random, or stalled
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NDUT; i++)
      rr[i] = (rmode == 0) ? 1'b1 : ((rmode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0);
  end

  // Monitor: compare whatever the active responder presents
  always @(negedge clk) begin
    rdy_s = rdy[sel];
    if (mon_en) begin
      check("req_ready", 32'(rdy[sel]), 32'((exp_q.size() == 0) || (vld[sel] && rr[sel])));
      if (vld[sel]) begin
        if (exp_q.size() == 0) begin
          check("resp_valid_unexpected", 32'(vld[sel]), 32'h0);
          hold = 1'b0;
        end else begin
          if (!hold) check("resp_latency", ecnt, exp_q[0].due);
          check("resp_data", dat[sel], exp_q[0].data);
          check("resp_err", 32'(err[sel]), 32'(exp_q[0].err));
          if (rr[sel]) begin
            void'(exp_q.pop_front());
            hold = 1'b0;
          end else begin
            hold = 1'b1;
          end
        end
      end else begin
        hold = 1'b0;
      end
      if (rst) hold = 1'b0;
    end
  end

  task automatic prog_write(input int idx, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = AW'(idx);
    prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // Present a request until accepted; any pending program write lasts one edge
  task automatic issue(input int d, input logic [31:0] a);
    logic acc;
    int   n;
    n     = 0;
    rv[d] = 1'b1;
    ra[d] = a;
    forever begin
      @(negedge clk);
      acc = rdy[d];
      @(posedge clk); #1;
      prog_we = 1'b0;
      if (acc) break;
      n++;
      if (n > 60) begin
        check("accept_timeout", 32'(acc), 32'h1);
        break;
      end
    end
    rv[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    errors = 0; checks = 0; ecnt = 0; sel = 0; rmode = 0;
    mon_en = 1'b0; hold = 1'b0;
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    for (int i = 0; i < NDUT; i++) begin rv[i] = 1'b0; ra[i] = '0; end
    repeat (2) @(posedge clk); #1;
    // Preload while in reset: program writes must commit regardless
    for (int i = 0; i < DEPTH; i++) prog_write(i, $urandom);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check("reset_req_ready", 32'(rdy[i]), 32'h1);
      check("reset_resp_valid", 32'(vld[i]), 32'h0);
      check("reset_resp_err", 32'(err[i]), 32'h0);
      check("reset_resp_data", dat[i], 32'h0);
    end
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Basic fetch, latency 1
    prog_write(0, 32'h0000_0513);
    prog_write(1, 32'h0015_0513);
    prog_write(2, EBREAK_INST);
    prog_write(3, 32'hDEAD_BEEF);
    sel = 0;
    issue(0, 32'h8000_0000);
    drain();

    // Back-to-back streaming
    issue(0, 32'h8000_0000);
    issue(0, 32'h8000_0004);
    issue(0, 32'h8000_0008);
    drain();

    // Latency 4 with backpressure
    sel = 1; rmode = 2;
    @(posedge clk); #1;
    issue(1, 32'h8000_000C);
    for (int n = 0; n < 20 && !vld[1]; n++) @(negedge clk);
    check("stall_valid_seen", 32'(vld[1]), 32'h1);
    repeat (2) @(negedge clk);
    rmode = 0;
    drain();

    // Faults then a legal fetch
    sel = 0;
    @(posedge clk); #1;
    issue(0, 32'h8000_0002);
    issue(0, 32'h7FFF_FFFC);
    issue(0, RESET_PC + DEPTH * 4);
    issue(0, RESET_PC + (DEPTH - 1) * 4);
    issue(0, 32'h8000_0004);
    drain();

    // Same-edge program write to the word being fetched
    prog_we = 1'b1; prog_addr = AW'(1); prog_data = 32'h1234_5678;
    issue(0, 32'h8000_0004);
    issue(0, 32'h8000_0004);
    drain();

    // Reset during WAIT on the latency-8 responder
    sel = 2;
    @(posedge clk); #1;
    issue(2, 32'h8000_0008);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    prog_we = 1'b1; prog_addr = AW'(5); prog_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rst = 1'b0; prog_we = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      check("post_reset_no_valid", 32'(vld[2]), 32'h0);
      check("post_reset_ready", 32'(rdy[2]), 32'h1);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) issue(2, RESET_PC + 32'(i * 4));
    drain();

    // Randomized traffic with random stalls and concurrent program writes
    for (int b = 0; b < 30; b++) begin
      sel   = $urandom_range(0, NDUT - 1);
      rmode = 1;
      @(posedge clk); #1;
      for (int n = 0; n < 10; n++) begin
        case ($urandom_range(0, 5))
          0:       a = $urandom;
          1:       a = RESET_PC + 32'($urandom_range(0, DEPTH * 4 - 1));
          default: a = RESET_PC + 32'($urandom_range(0, DEPTH - 1) * 4);
        endcase
        if ($urandom_range(0, 3) == 0) begin
          prog_we   = 1'b1;
          prog_addr = AW'($urandom_range(0, DEPTH - 1));
          prog_data = $urandom;
        end
        issue(sel, a);
      end
      drain();
    end
    rmode = 0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_imem_responder
`default_nettype wire
